// File: rtl/iter_alu.sv
// Multi-cycle ALU with a start/done handshake: one-cycle logic/shift/add ops,
// plus bit-serial signed Booth multiply and unsigned restoring divide.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        ALUopp,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z,
    output logic               div_zero,
    output logic               op_err
);

    localparam logic [15:0] OP_ADD = 16'h0001;
    localparam logic [15:0] OP_SUB = 16'h0002;
    localparam logic [15:0] OP_NEG = 16'h0004;
    localparam logic [15:0] OP_MUL = 16'h0008;
    localparam logic [15:0] OP_DIV = 16'h0010;
    localparam logic [15:0] OP_AND = 16'h0020;
    localparam logic [15:0] OP_OR  = 16'h0040;
    localparam logic [15:0] OP_ROR = 16'h0080;
    localparam logic [15:0] OP_ROL = 16'h0100;
    localparam logic [15:0] OP_SLL = 16'h0200;
    localparam logic [15:0] OP_SRA = 16'h0400;
    localparam logic [15:0] OP_SRL = 16'h0800;
    localparam logic [15:0] OP_NOT = 16'h1000;
    localparam logic [15:0] OP_INC = 16'h2000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               div_zero_q, div_zero_d;
    logic               op_err_q, op_err_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_div_q, is_div_d;

    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_err;
    logic               accept;

    logic [WIDTH:0]     booth_m, booth_sum;
    logic [WIDTH:0]     rem_shift, trial;
    logic [WIDTH:0]     it_acc;
    logic [WIDTH-1:0]   it_lo;
    logic               it_qm1;

    assign amt    = y[SHW-1:0];
    assign rot_r  = {x, x} >> amt;
    assign rot_l  = {x, x} << amt;
    assign accept = start && (state_q != S_ITER);

    // Single-cycle result; any opcode that is not exactly one legal bit is an error.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sc_res = '0;
        sc_err = 1'b0;
        case (ALUopp)
            OP_ADD:         sc_res = x + y;
            OP_SUB:         sc_res = x - y;
            OP_NEG:         sc_res = '0 - x;
            OP_MUL, OP_DIV: sc_res = '0;
            OP_AND:         sc_res = x & y;
            OP_OR:          sc_res = x | y;
            OP_ROR:         sc_res = rot_r[WIDTH-1:0];
            OP_ROL:         sc_res = rot_l[2*WIDTH-1:WIDTH];
            OP_SLL:         sc_res = x << amt;
            OP_SRA:         sc_res = $signed(x) >>> amt;
            OP_SRL:         sc_res = x >> amt;
            OP_NOT:         sc_res = ~x;
            OP_INC:         sc_res = x + WIDTH'(1);
            default:        sc_err = 1'b1;
        endcase
    end

    // acc carries one guard bit so Booth handles the most negative multiplicand.
    assign booth_m   = {opnd_q[WIDTH-1], opnd_q};
    assign rem_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, opnd_q};

    always_comb begin
        it_acc    = acc_q;
        it_lo     = lo_q;
        it_qm1    = qm1_q;
        booth_sum = acc_q;
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                it_acc = trial;
                it_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                it_acc = rem_shift;
                it_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            case ({lo_q[0], qm1_q})
                2'b01:   booth_sum = acc_q + booth_m;
                2'b10:   booth_sum = acc_q - booth_m;
                default: booth_sum = acc_q;
            endcase
            it_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            it_lo  = {booth_sum[0], lo_q[WIDTH-1:1]};
            it_qm1 = lo_q[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        div_zero_d = div_zero_q;
        op_err_d   = op_err_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        qm1_d      = qm1_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        case (state_q)
            S_ITER: begin
                acc_d = it_acc;
                lo_d  = it_lo;
                qm1_d = it_qm1;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d    = S_DONE;
                    z_d        = {it_acc[WIDTH-1:0], it_lo};
                    div_zero_d = is_div_q && (opnd_q == '0);
                end
            end
            default: begin
                if (accept) begin
                    div_zero_d = 1'b0;
                    cnt_d      = '0;
                    if (ALUopp == OP_MUL || ALUopp == OP_DIV) begin
                        state_d  = S_ITER;
                        z_d      = '0;
                        op_err_d = 1'b0;
                        is_div_d = (ALUopp == OP_DIV);
                        acc_d    = '0;
                        qm1_d    = 1'b0;
                        lo_d     = (ALUopp == OP_DIV) ? x : y;
                        opnd_d   = (ALUopp == OP_DIV) ? y : x;
                    end else begin
                        state_d  = S_DONE;
                        z_d      = {{WIDTH{1'b0}}, sc_res};
                        op_err_d = sc_err;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            z_q        <= '0;
            div_zero_q <= 1'b0;
            op_err_q   <= 1'b0;
            acc_q      <= '0;
            lo_q       <= '0;
            qm1_q      <= 1'b0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            z_q        <= z_d;
            div_zero_q <= div_zero_d;
            op_err_q   <= op_err_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            qm1_q      <= qm1_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
        end
    end

    assign busy     = (state_q == S_ITER);
    assign done     = (state_q == S_DONE);
    assign Z        = z_q;
    assign div_zero = div_zero_q;
    assign op_err   = op_err_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at WIDTH=32 and WIDTH=8: stimulus pushes
// expected results, per-instance monitors pop and compare on done.
module tb_iter_alu;

    localparam logic [15:0] OP_ADD = 16'h0001;
    localparam logic [15:0] OP_SUB = 16'h0002;
    localparam logic [15:0] OP_NEG = 16'h0004;
    localparam logic [15:0] OP_MUL = 16'h0008;
    localparam logic [15:0] OP_DIV = 16'h0010;
    localparam logic [15:0] OP_AND = 16'h0020;
    localparam logic [15:0] OP_OR  = 16'h0040;
    localparam logic [15:0] OP_ROR = 16'h0080;
    localparam logic [15:0] OP_ROL = 16'h0100;
    localparam logic [15:0] OP_SLL = 16'h0200;
    localparam logic [15:0] OP_SRA = 16'h0400;
    localparam logic [15:0] OP_SRL = 16'h0800;
    localparam logic [15:0] OP_NOT = 16'h1000;
    localparam logic [15:0] OP_INC = 16'h2000;

    typedef struct {
        logic [63:0] z;
        logic        dz;
        logic        oe;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst32, rst8;
    logic        start32, start8;
    logic [15:0] op32, op8;
    logic [31:0] x32, y32;
    logic [7:0]  x8, y8;
    logic        busy32, done32, dz32, oe32;
    logic        busy8, done8, dz8, oe8;
    logic [63:0] z32;
    logic [15:0] z8;

    exp_t q32[$];
    exp_t q8[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst32), .start(start32), .ALUopp(op32), .x(x32), .y(y32),
        .busy(busy32), .done(done32), .Z(z32), .div_zero(dz32), .op_err(oe32)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .ALUopp(op8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .Z(z8), .div_zero(dz8), .op_err(oe8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                check("w32 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check({e.name, " Z"}, z32, e.z);
                check({e.name, " div_zero"}, 64'(dz32), 64'(e.dz));
                check({e.name, " op_err"}, 64'(oe32), 64'(e.oe));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("w8 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check({e.name, " Z"}, 64'(z8), e.z);
                check({e.name, " div_zero"}, 64'(dz8), 64'(e.dz));
                check({e.name, " op_err"}, 64'(oe8), 64'(e.oe));
            end
        end
    end

    // Issue one op, scramble inputs right after the accept edge, and time the response.
    task automatic run_op(input bit w8, input logic [15:0] op, input logic [63:0] xa,
                          input logic [63:0] ya, input logic [63:0] ez, input bit edz,
                          input bit eoe, input string name);
        exp_t e;
        int   lat, bcnt, elat;
        bit   iter, seen;
        iter = (op == OP_MUL) || (op == OP_DIV);
        elat = iter ? (w8 ? 9 : 33) : 1;
        e.z = ez; e.dz = edz; e.oe = eoe; e.name = name;
        @(negedge clk);
        if (w8) begin
            x8 = xa[7:0]; y8 = ya[7:0]; op8 = op; start8 = 1'b1; q8.push_back(e);
        end else begin
            x32 = xa[31:0]; y32 = ya[31:0]; op32 = op; start32 = 1'b1; q32.push_back(e);
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; start32 = 1'b0;
        x32 = $urandom; y32 = $urandom; op32 = 16'($urandom);
        x8 = 8'($urandom); y8 = 8'($urandom); op8 = 16'($urandom);
        lat = 0; bcnt = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (w8 ? busy8 : busy32) bcnt++;
            seen = w8 ? done8 : done32;
        end
        check({name, " latency"}, 64'(lat), 64'(elat));
        check({name, " busy cycles"}, 64'(bcnt), 64'(elat - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   cyc, dn, last;
        rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
        op32 = '0; op8 = '0; x32 = '0; y32 = '0; x8 = '0; y8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset32 busy/done/dz/oe", {busy32, done32, dz32, oe32}, 0);
        check("reset32 Z", z32, 0);
        check("reset8 busy/done/dz/oe", {busy8, done8, dz8, oe8}, 0);
        check("reset8 Z", 64'(z8), 0);
        @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;

        run_op(0, OP_ADD, 10, 5, 64'd15, 0, 0, "ADD 10+5");
        run_op(0, OP_SUB, 15, 5, 64'd10, 0, 0, "SUB 15-5");
        run_op(0, OP_NEG, 7, 0, 64'h0000_0000_FFFF_FFF9, 0, 0, "NEG 7");
        run_op(0, OP_INC, 64'hFFFF_FFFF, 0, 64'd0, 0, 0, "INC wrap");
        run_op(0, OP_AND, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'hF000_F000, 0, 0, "AND");
        run_op(0, OP_OR, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'hFFF0_FFF0, 0, 0, "OR");
        run_op(0, OP_NOT, 64'h0F0F_0F0F, 0, 64'hF0F0_F0F0, 0, 0, "NOT");
        run_op(0, OP_MUL, 64'hFFFF_FFFD, 4, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0, "MUL -3*4");
        run_op(0, OP_MUL, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, "MUL min*min");
        run_op(0, OP_MUL, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0, 0, "MUL max*-1");
        run_op(0, OP_DIV, 20, 3, 64'h0000_0002_0000_0006, 0, 0, "DIV 20/3");
        run_op(0, OP_DIV, 7, 0, 64'h0000_0007_FFFF_FFFF, 1, 0, "DIV 7/0");
        run_op(0, OP_DIV, 64'hFFFF_FFFF, 16, 64'h0000_000F_0FFF_FFFF, 0, 0, "DIV max/16");
        run_op(0, OP_SRA, 64'h8000_0001, 64'h21, 64'hC000_0000, 0, 0, "SRA amt 0x21");
        run_op(0, OP_ROR, 64'h8000_0001, 1, 64'hC000_0000, 0, 0, "ROR 1");
        run_op(0, OP_ROL, 64'h8000_0001, 4, 64'h0000_0018, 0, 0, "ROL 4");
        run_op(0, OP_SLL, 64'h8000_0001, 31, 64'h8000_0000, 0, 0, "SLL 31");
        run_op(0, OP_SRL, 64'h8000_0001, 0, 64'h8000_0001, 0, 0, "SRL 0");
        run_op(0, OP_SRL, 64'h8000_0001, 4, 64'h0800_0000, 0, 0, "SRL 4");
        run_op(0, 16'h0003, 5, 5, 64'd0, 0, 1, "illegal 0x0003");
        run_op(0, 16'h0000, 5, 5, 64'd0, 0, 1, "illegal 0x0000");
        run_op(0, 16'h4000, 5, 5, 64'd0, 0, 1, "illegal 0x4000");
        run_op(0, OP_AND, 3, 6, 64'd2, 0, 0, "AND clears op_err");

        // Reset during DIV iteration 10: no done, everything cleared.
        @(negedge clk);
        op32 = OP_DIV; x32 = 1000; y32 = 3; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        check("DIV busy before reset", 64'(busy32), 1);
        rst32 = 1'b1;
        @(posedge clk);
        #1;
        check("mid-DIV reset busy/done/dz/oe", {busy32, done32, dz32, oe32}, 0);
        check("mid-DIV reset Z", z32, 0);
        @(negedge clk);
        rst32 = 1'b0;
        run_op(0, OP_ADD, 1, 2, 64'd3, 0, 0, "ADD after reset");

        // start held high: back-to-back MULs, one per 33 cycles.
        @(negedge clk);
        op32 = OP_MUL; x32 = 32'hFFFF_FFFB; y32 = 6;
        e.z = 64'hFFFF_FFFF_FFFF_FFE2; e.dz = 1'b0; e.oe = 1'b0; e.name = "MUL held start";
        repeat (3) q32.push_back(e);
        start32 = 1'b1;
        cyc = 0; dn = 0; last = 0;
        while (dn < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                dn++;
                check("held-start done spacing", 64'(cyc - last), 33);
                last = cyc;
                if (dn == 3) start32 = 1'b0;
            end
        end
        check("held-start done count", 64'(dn), 3);

        run_op(1, OP_MUL, 8'hFD, 4, 64'hFFF4, 0, 0, "W8 MUL -3*4");
        run_op(1, OP_MUL, 8'h80, 8'h80, 64'h4000, 0, 0, "W8 MUL min*min");
        run_op(1, OP_DIV, 200, 7, 64'h041C, 0, 0, "W8 DIV 200/7");
        run_op(1, OP_SRA, 8'h81, 8'h21, 64'hC0, 0, 0, "W8 SRA amt 0x21");
        run_op(1, OP_ROR, 8'h81, 1, 64'hC0, 0, 0, "W8 ROR 1");
        run_op(1, OP_ROL, 8'h81, 4, 64'h18, 0, 0, "W8 ROL 4");
        run_op(1, OP_SLL, 8'h81, 7, 64'h80, 0, 0, "W8 SLL 7");
        run_op(1, OP_SRL, 8'h81, 0, 64'h81, 0, 0, "W8 SRL 0");

        repeat (3) @(negedge clk);
        check("w32 scoreboard drained", 64'(q32.size()), 0);
        check("w8 scoreboard drained", 64'(q8.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
